// File: rtl/dpram_bist_ctrl.sv
// dpram_bist_ctrl
// March-style fill/readback self-test for the dual-port RAM.
// Port A writes pat(addr) = addr ^ seed to every word. Port B reads every word back.
// Each readback is compared against the pattern after rd_lat cycles.
// The test stops at the first mismatch, or runs to the end and reports pass.
//
// Optional build macro: DPRAM_BIST_ERRCNT_EN
//   When defined, an err_cnt output is added and the test never aborts.
//   Every mismatching word is counted, saturating at depth.
//   pass is then (err_cnt == 0).
//
// Legal rd_lat range is 1..4.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; results of the last test held
// S_WRITE  | port A fills one word per cycle, addr_a 0..depth-1
// S_READ   | port B issues one read per cycle, addr_b 0..depth-1
// S_DRAIN  | no new reads; waiting for outstanding reads to be compared
// S_DONE   | one-cycle done pulse, then back to S_IDLE

module dpram_bist_ctrl #(
    parameter int data_width = 8,
    parameter int addr_width = 6,
    parameter int rd_lat     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [data_width-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [addr_width-1:0] fail_addr,
    output logic [data_width-1:0] fail_exp,
    output logic [data_width-1:0] fail_got,
    output logic [data_width-1:0] data_a,
    output logic [addr_width-1:0] addr_a,
    output logic                  a,
    output logic [data_width-1:0] data_b,
    output logic [addr_width-1:0] addr_b,
    output logic                  b,
    input  logic [data_width-1:0] out_b
`ifdef DPRAM_BIST_ERRCNT_EN
    ,
    output logic [addr_width:0]   err_cnt
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Terminal count for both address counters; the counters never wrap.
    localparam logic [addr_width-1:0] last_addr = '1;

    logic [2:0]            state;
    logic [data_width-1:0] seed_q;

    // Outstanding reads: entry i holds a read issued i+1 cycles ago.
    // The oldest entry lines up with out_b.
    logic [rd_lat-1:0]     pipe_vld;
    logic [addr_width-1:0] pipe_adr [rd_lat];

    logic                  issue;
    logic                  exit_vld;
    logic [addr_width-1:0] exit_adr;
    logic [data_width-1:0] exit_exp;
    logic                  mismatch;
    logic                  abort;
    logic                  drain_empty;
    logic                  accept;
    logic                  pass_cand;

    // The address is zero-extended or truncated to word width, then XORed with the seed.
    function automatic logic [data_width-1:0] pat(input logic [addr_width-1:0] x,
                                                   input logic [data_width-1:0] s);
        return data_width'(x) ^ s;
    endfunction

    // Port-side decodes come straight from the state register.
    // Reset (state = IDLE) therefore forces every port output low.
    assign a      = (state == S_WRITE);
    assign data_a = a ? pat(addr_a, seed_q) : '0;
    assign data_b = '0;
    assign b      = 1'b0;
    assign busy   = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign done   = (state == S_DONE);

    // Readback compare happens at the pipe exit, in the same cycle out_b is valid.
    assign issue       = (state == S_READ);
    assign exit_vld    = pipe_vld[rd_lat-1];
    assign exit_adr    = pipe_adr[rd_lat-1];
    assign exit_exp    = pat(exit_adr, seed_q);
    assign mismatch    = exit_vld && (out_b != exit_exp);
    assign drain_empty = (state == S_DRAIN) && (pipe_vld == '0);
    assign accept      = (state == S_IDLE) && start;

`ifdef DPRAM_BIST_ERRCNT_EN
    // Counting build: every word is read, so a mismatch never cuts the run short.
    assign abort = 1'b0;
`else
    assign abort = mismatch;
`endif

    // Sequencer: state, seed capture and the two address counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            seed_q <= '0;
            addr_a <= '0;
            addr_b <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed_q <= seed;
                        addr_a <= '0;
                        addr_b <= '0;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (addr_a == last_addr) begin
                        addr_a <= '0;
                        state  <= S_READ;
                    end else begin
                        addr_a <= addr_a + addr_width'(1);
                    end
                end
                S_READ: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else if (addr_b == last_addr) begin
                        state <= S_DRAIN;
                    end else begin
                        addr_b <= addr_b + addr_width'(1);
                    end
                end
                S_DRAIN: begin
                    if (abort || (pipe_vld == '0)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-latency pipe: shifts the issued address along with its valid bit.
    // An abort empties the pipe so that no stale compare reaches the next test.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < rd_lat; i++) begin
                pipe_adr[i] <= '0;
            end
        end else if (abort) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue;
            pipe_adr[0] <= addr_b;
            for (int i = 1; i < rd_lat; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_adr[i] <= pipe_adr[i-1];
            end
        end
    end

    // Result capture: first-failure record, pass candidate, and the final verdict at done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pass      <= 1'b0;
            pass_cand <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else if (accept) begin
            pass      <= 1'b0;
            pass_cand <= 1'b1;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
        end else begin
            if (mismatch && pass_cand) begin
                fail_addr <= exit_adr;
                fail_exp  <= exit_exp;
                fail_got  <= out_b;
                pass_cand <= 1'b0;
            end
            if (drain_empty) begin
`ifdef DPRAM_BIST_ERRCNT_EN
                pass <= (err_cnt == '0);
`else
                pass <= pass_cand;
`endif
            end
        end
    end

`ifdef DPRAM_BIST_ERRCNT_EN
    localparam logic [addr_width:0] depth_cnt = {1'b1, {addr_width{1'b0}}};

    // Mismatch counter: saturates at depth, so every word failing is still representable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (accept) begin
            err_cnt <= '0;
        end else if (mismatch && (err_cnt != depth_cnt)) begin
            err_cnt <= err_cnt + (addr_width + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// tb_dpram_bist_ctrl
// This bench runs two controllers side by side on shared start and seed: one with rd_lat=1 and one with rd_lat=3.
// Each controller drives its own behavioural dual-port RAM, and both RAMs share a configurable stuck-bit fault map.
// Expected results come from an array-level model of the fill/readback.
// Build with DPRAM_BIST_ERRCNT_EN defined to exercise the counting variant.

module tb_dpram_bist_ctrl;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int D  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;

    logic [1:0]      busy_p, done_p, pass_p, a_p, b_p;
    logic [2*AW-1:0] fail_addr_p, addr_a_p, addr_b_p;
    logic [2*DW-1:0] fail_exp_p, fail_got_p, data_a_p, data_b_p, out_b_p;
`ifdef DPRAM_BIST_ERRCNT_EN
    logic [2*(AW+1)-1:0] err_cnt_p;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Read-path fault map, applied by both RAM models.
    int            flt_n = 0;
    logic [AW-1:0] flt_addr [2];
    int            flt_bit  [2];
    bit            flt_val  [2];

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] apply_fault(input logic [AW-1:0] x, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        for (int i = 0; i < flt_n; i++) begin
            if (flt_addr[i] == x) r[flt_bit[i]] = flt_val[i];
        end
        return r;
    endfunction

    function automatic int lane_lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int L = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem [D];
        logic [DW-1:0] q   [L];

        dpram_bist_ctrl #(.data_width(DW), .addr_width(AW), .rd_lat(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .seed      (seed),
            .busy      (busy_p[g]),
            .done      (done_p[g]),
            .pass      (pass_p[g]),
            .fail_addr (fail_addr_p[g*AW +: AW]),
            .fail_exp  (fail_exp_p[g*DW +: DW]),
            .fail_got  (fail_got_p[g*DW +: DW]),
            .data_a    (data_a_p[g*DW +: DW]),
            .addr_a    (addr_a_p[g*AW +: AW]),
            .a         (a_p[g]),
            .data_b    (data_b_p[g*DW +: DW]),
            .addr_b    (addr_b_p[g*AW +: AW]),
            .b         (b_p[g]),
            .out_b     (out_b_p[g*DW +: DW])
`ifdef DPRAM_BIST_ERRCNT_EN
            ,
            .err_cnt   (err_cnt_p[g*(AW+1) +: AW+1])
`endif
        );

        // RAM model: synchronous write on port A, and a read on port B that appears L cycles later.
        always @(posedge clk) begin
            if (a_p[g]) mem[addr_a_p[g*AW +: AW]] <= data_a_p[g*DW +: DW];
            q[0] <= apply_fault(addr_b_p[g*AW +: AW], mem[addr_b_p[g*AW +: AW]]);
            for (int s = 1; s < L; s++) q[s] <= q[s-1];
        end
        assign out_b_p[g*DW +: DW] = q[L-1];
    end

    task automatic chk(input string tag, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic string tg(input int g, input string s);
        return $sformatf("L%0d_%s", lane_lat(g), s);
    endfunction

    // Array-level reference: fill every word with pat(x), read it back through the fault map,
    // and find the first failing word and the total failure count.
    task automatic model(input logic [DW-1:0] sd, output bit e_pass, output int e_first,
                         output logic [DW-1:0] e_exp, output logic [DW-1:0] e_got,
                         output int e_nerr);
        logic [DW-1:0] w, r;
        e_first = -1;
        e_nerr  = 0;
        e_exp   = '0;
        e_got   = '0;
        for (int x = 0; x < D; x++) begin
            w = DW'(x) ^ sd;
            r = apply_fault(AW'(x), w);
            if (r != w) begin
                if (e_first < 0) begin
                    e_first = x;
                    e_exp   = w;
                    e_got   = r;
                end
                e_nerr++;
            end
        end
        e_pass = (e_nerr == 0);
    endtask

    task automatic run_test(input logic [DW-1:0] sd, input bit poke, input bit chk_early_stop);
        bit            e_pass;
        int            e_first, e_nerr, k, clean_lat;
        logic [DW-1:0] e_exp, e_got;
        bit            seen [2];
        int            lat [2], wcnt [2], wbad [2], pbbad [2], maxb [2];
        bit            r_pass [2], k1_ok [2];
        int            r_faddr [2], r_fexp [2], r_fgot [2], r_err [2], wd10 [2];

        model(sd, e_pass, e_first, e_exp, e_got, e_nerr);
        for (int g = 0; g < 2; g++) begin
            seen[g] = 0; lat[g] = 0; wcnt[g] = 0; wbad[g] = 0; pbbad[g] = 0; maxb[g] = 0;
            r_pass[g] = 0; k1_ok[g] = 0; r_faddr[g] = 0; r_fexp[g] = 0; r_fgot[g] = 0;
            r_err[g] = 0; wd10[g] = -1;
        end

        @(negedge clk);
        seed  = sd;
        start = 1'b1;
        k = 0;
        while (!(seen[0] && seen[1]) && (k < 2*D + 20)) begin
            @(negedge clk);
            k++;
            for (int g = 0; g < 2; g++) begin
                if (k == 1) k1_ok[g] = busy_p[g] && !pass_p[g] && !done_p[g];
                if (!seen[g]) begin
                    if (a_p[g]) begin
                        wcnt[g]++;
                        if (data_a_p[g*DW +: DW] != (DW'(addr_a_p[g*AW +: AW]) ^ sd)) wbad[g]++;
                        if (addr_a_p[g*AW +: AW] == AW'(16)) wd10[g] = int'(data_a_p[g*DW +: DW]);
                    end
                    if (b_p[g] || (data_b_p[g*DW +: DW] != '0)) pbbad[g]++;
                    if (busy_p[g] && (int'(addr_b_p[g*AW +: AW]) > maxb[g]))
                        maxb[g] = int'(addr_b_p[g*AW +: AW]);
                    if (done_p[g]) begin
                        seen[g]    = 1;
                        lat[g]     = k;
                        r_pass[g]  = pass_p[g];
                        r_faddr[g] = int'(fail_addr_p[g*AW +: AW]);
                        r_fexp[g]  = int'(fail_exp_p[g*DW +: DW]);
                        r_fgot[g]  = int'(fail_got_p[g*DW +: DW]);
`ifdef DPRAM_BIST_ERRCNT_EN
                        r_err[g]   = int'(err_cnt_p[g*(AW+1) +: AW+1]);
`endif
                    end
                end
            end
            start = 1'b0;
            if (poke && ((k == 10) || (done_p[0] && lat[0] == k))) start = 1'b1;
        end
        start = 1'b0;

        for (int g = 0; g < 2; g++) begin
            clean_lat = 2*D + lane_lat(g) + 2;
            chk(tg(g, "done_seen"), int'(seen[g]), 1);
            chk(tg(g, "start_accept"), int'(k1_ok[g]), 1);
            chk(tg(g, "pass"), int'(r_pass[g]), int'(e_pass));
            chk(tg(g, "fail_addr"), r_faddr[g], (e_first < 0) ? 0 : e_first);
            chk(tg(g, "fail_exp"), r_fexp[g], int'(e_exp));
            chk(tg(g, "fail_got"), r_fgot[g], int'(e_got));
            chk(tg(g, "write_count"), wcnt[g], D);
            chk(tg(g, "write_data_bad"), wbad[g], 0);
            chk(tg(g, "word16"), wd10[g], int'(8'h10 ^ sd));
            chk(tg(g, "portb_write"), pbbad[g], 0);
`ifdef DPRAM_BIST_ERRCNT_EN
            chk(tg(g, "latency"), lat[g], clean_lat);
            chk(tg(g, "err_cnt"), r_err[g], e_nerr);
`else
            if (e_pass) begin
                chk(tg(g, "latency"), lat[g], clean_lat);
            end else begin
                chk(tg(g, "early_done"), int'(lat[g] < clean_lat), 1);
                if (chk_early_stop) chk(tg(g, "reads_cut_short"), int'(maxb[g] < D-1), 1);
            end
`endif
        end

        if (poke) begin
            repeat (3) @(negedge clk);
            chk("L1_idle_after_poke", int'(busy_p[0]), 0);
            chk("L3_idle_after_poke", int'(busy_p[1]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst   = 1'b0;
        start = 1'b0;
        seed  = '0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk(tg(g, "rst_busy"), int'(busy_p[g]), 0);
            chk(tg(g, "rst_done"), int'(done_p[g]), 0);
            chk(tg(g, "rst_pass"), int'(pass_p[g]), 0);
            chk(tg(g, "rst_a"), int'(a_p[g]), 0);
            chk(tg(g, "rst_addr_a"), int'(addr_a_p[g*AW +: AW]), 0);
            chk(tg(g, "rst_data_a"), int'(data_a_p[g*DW +: DW]), 0);
            chk(tg(g, "rst_addr_b"), int'(addr_b_p[g*AW +: AW]), 0);
            chk(tg(g, "rst_fail_addr"), int'(fail_addr_p[g*AW +: AW]), 0);
            chk(tg(g, "rst_fail_got"), int'(fail_got_p[g*DW +: DW]), 0);
        end

        // Directed: clean runs with seed 00 and seed A5.
        flt_n = 0;
        run_test(8'h00, 0, 0);
        run_test(8'hA5, 0, 0);

        // Directed: bit 3 of word 37 stuck at 1.
        flt_n = 1; flt_addr[0] = AW'(37); flt_bit[0] = 3; flt_val[0] = 1'b1;
        run_test(8'h00, 0, 1);

        // Directed: a clean run leaves pass=1; reset while writing word 20.
        flt_n = 0;
        run_test(8'h3C, 0, 0);
        @(negedge clk);
        seed  = 8'h5A;
        start = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (a_p[0] && addr_a_p[AW-1:0] == AW'(20)) found = 1;
        end
        chk("mid_write_reached", int'(found), 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            chk(tg(g, "midrst_busy"), int'(busy_p[g]), 0);
            chk(tg(g, "midrst_a"), int'(a_p[g]), 0);
            chk(tg(g, "midrst_addr_a"), int'(addr_a_p[g*AW +: AW]), 0);
            chk(tg(g, "midrst_pass"), int'(pass_p[g]), 0);
        end
        run_test(8'h5A, 0, 0);

        // Directed: start pulses while busy and on the done cycle, then a normal start.
        run_test(8'hC3, 1, 0);
        run_test(8'h81, 0, 0);

        // Random: random seeds with zero, one or two stuck bits.
        for (int r = 0; r < 8; r++) begin
            flt_n = $urandom_range(0, 2);
            for (int f = 0; f < 2; f++) begin
                flt_addr[f] = AW'($urandom_range(0, D-1));
                flt_bit[f]  = $urandom_range(0, DW-1);
                flt_val[f]  = 1'($urandom_range(0, 1));
            end
            run_test(DW'($urandom), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dpram_bist_ctrl.md
Name: dpram_bist_ctrl

Overview:
- Initiator that drives both ports of the team's dual-port RAM (`dual_port_ram`) as a memory built-in self-test.
- Fills every location through port A with an address-derived pattern, reads every location back through port B, compares, and reports pass or first failure.
- Sits between the system control logic (start, status) and the RAM port pins. Replaces the hand-written fill/readback bench sequencing in hardware.

Parameters:
- data_width, 8, RAM word width in bits
- addr_width, 6, RAM address width; depth = 2**addr_width
- rd_lat, 1, cycles from port-B address presented to out_b valid (legal range 1..4)

Ports:
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse; begins a test when IDLE, ignored otherwise
- seed  input  data_width  pattern seed, sampled on accepted start
- busy  output  1  high from accepted start until done asserts
- done  output  1  one-cycle pulse when the test ends
- pass  output  1  result of last test, valid from done until next start
- fail_addr  output  addr_width  address of first mismatch
- fail_exp  output  data_width  expected word at fail_addr
- fail_got  output  data_width  read word at fail_addr
- data_a  output  data_width  RAM port-A write data
- addr_a  output  addr_width  RAM port-A address
- a  output  1  RAM port-A write enable
- data_b  output  data_width  RAM port-B write data, constant 0
- addr_b  output  addr_width  RAM port-B address
- b  output  1  RAM port-B write enable, constant 0
- out_b  input  data_width  RAM port-B read data

Behaviour:
- Reset (rst=0 at a clock edge) forces all outputs to 0, the FSM to IDLE and the latency pipeline to empty. Reset is honoured mid-test.
- Pattern: pat(x) = {x zero-extended or truncated to data_width} XOR seed_q.
- FSM states and transitions:
  - IDLE: start=1 captures seed into seed_q, clears pass/fail_*, sets busy=1, moves to WRITE with addr_a=0.
  - WRITE: a=1, data_a=pat(addr_a), one word per cycle. After addr_a = depth-1 is written, go to READ; a drops to 0 the cycle after.
  - READ: b=0, addr_b steps 0..depth-1, one address per cycle. Each issued address enters an rd_lat-deep valid/address shift pipe. After issuing depth-1, go to DRAIN.
  - DRAIN: no new addresses; wait for the pipe to empty, then go to DONE.
  - DONE: done=1 for one cycle, busy=0 the same cycle, then return to IDLE.
- Compare: when a pipe entry with address x exits, compare out_b against pat(x).
  - On the first mismatch: latch fail_addr=x, fail_exp, fail_got, clear the pass candidate, abort the remaining reads, flush the pipe, and go to DONE.
- pass=1 only if all depth words match. It is updated on the done cycle.
- Write-to-read turnaround: the first port-B read is issued the cycle after the last port-A write, so the RAM must provide write-then-read on consecutive cycles.
- Timing for a clean run: start to done = 2*depth + rd_lat + 2 cycles.
- Port B never writes and port A never reads, so there are no same-address collisions.
- Address counters do not wrap: terminal count is detected explicitly at depth-1.
- start during busy is ignored. start in the same cycle as rst=0 is ignored.

Optional Feature:
- Macro: DPRAM_BIST_ERRCNT_EN.
- When defined:
  - Adds output err_cnt, addr_width+1 bits, reset 0, cleared on accepted start.
  - The test does not abort on mismatch; every mismatch increments err_cnt, saturating at depth.
  - fail_* still holds the first mismatch.
  - pass = (err_cnt==0) at done.
  - Run length is always the full 2*depth + rd_lat + 2 cycles.
- When undefined: no err_cnt port; abort-on-first-mismatch behaviour as above.

Test Plan:
- Clean run, seed=8'h00, rd_lat=1, RAM model correct -> addresses 0..63 written with data 0..63; done at cycle 131 after start; pass=1; fail_addr=0.
- seed=8'hA5 -> data_a at addr 6'h10 = 8'hB5; pass=1.
- Fault injection: RAM model stuck bit 3 at addr 37, seed=0 -> pass=0, fail_addr=37, fail_exp=8'h25, fail_got=8'h2D; done before address 63 is read (or full run with err_cnt=1 when DPRAM_BIST_ERRCNT_EN is defined).
- rst=0 asserted for one cycle mid-WRITE at addr 20 -> next cycle: busy=0, a=0, addr_a=0, pass=0; a fresh start then completes with pass=1.
- start pulsed while busy, and again at the done cycle -> the first is ignored; a start at the done cycle is ignored (FSM still in DONE); the next start after return to IDLE is accepted.
- rd_lat=3 parameter sweep, clean RAM -> pass=1, done at 133 cycles after start; no false mismatch at address 0 or 63.
